// File: rtl/bullet_pool.sv
// bullet_pool: fixed pool of player bullets, stepped once per game tick.
// Each tick sweeps one slot per cycle, then tries one spawn.
module bullet_pool #(
  parameter int N_SLOTS  = 8,
  parameter int SPEED    = 4,
  parameter int BW       = 4,
  parameter int BH       = 8,
  parameter int COOLDOWN = 6,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          fire,
  input  logic          gameover,
  input  logic [CW-1:0] spawn_x,
  input  logic [CW-1:0] spawn_y,
  input  logic [CW-1:0] tgt_x,
  input  logic [CW-1:0] tgt_y,
  input  logic [CW-1:0] tgt_w,
  input  logic [CW-1:0] tgt_h,
  input  logic [CW-1:0] hc,
  input  logic [CW-1:0] vc,
  output logic          pix_bullet,
  output logic          hit_pulse,
  output logic [3:0]    hit_num,
  output logic [15:0]   hit_total,
  output logic [4:0]    active_cnt,
  output logic          busy,
  output logic          overrun
);
  localparam int IW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int XW = CW + 1;

  typedef enum logic [1:0] {IDLE, SWEEP, SPAWN} state_t;
  state_t state_q, state_d;

  logic [N_SLOTS-1:0] valid_q;
  logic [CW-1:0]      x_q [N_SLOTS];
  logic [CW-1:0]      y_q [N_SLOTS];
  logic [IW-1:0]      idx_q;
  logic [CW-1:0]      tx_q, ty_q, tw_q, th_q;
  logic [7:0]         cd_q;
  logic [4:0]         cnt_q;

  logic          last_slot;
  logic          cur_v, exits, overlap, hit;
  logic [CW-1:0] cur_x, cur_y, new_y;
  logic          free_found, do_spawn, pix_d;
  logic [IW-1:0] free_idx;
  logic [4:0]    pop_d;
  logic [16:0]   sum;

  assign busy      = (state_q != IDLE);
  assign last_slot = (idx_q == IW'(N_SLOTS - 1));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state: one sweep pass, then a single spawn cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = SWEEP;
      SWEEP:   if (last_slot) state_d = SPAWN;
      SPAWN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // move/retire decision for the slot under the sweep pointer
  always_comb begin
    cur_v   = valid_q[idx_q];
    cur_x   = x_q[idx_q];
    cur_y   = y_q[idx_q];
    exits   = (cur_y < CW'(SPEED));
    new_y   = cur_y - CW'(SPEED);
    overlap = ({1'b0, cur_x} < {1'b0, tx_q} + {1'b0, tw_q})
           && ({1'b0, tx_q} < {1'b0, cur_x} + XW'(BW))
           && ({1'b0, new_y} < {1'b0, ty_q} + {1'b0, th_q})
           && ({1'b0, ty_q} < {1'b0, new_y} + XW'(BH));
    hit     = cur_v && !gameover && !exits
           && (tw_q != '0) && (th_q != '0) && overlap;
  end

  // lowest free slot, live count, spawn gate, saturating total
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    pop_d      = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      pop_d = pop_d + 5'(valid_q[i]);
    end
    do_spawn = (state_q == SPAWN) && (cd_q == '0)
            && fire && !gameover && free_found;
    sum = {1'b0, hit_total} + 17'(cnt_q);
  end

  // any live bullet covering the current pixel
  always_comb begin
    pix_d = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (valid_q[i]
          && ({1'b0, hc} >= {1'b0, x_q[i]})
          && ({1'b0, hc} <  {1'b0, x_q[i]} + XW'(BW))
          && ({1'b0, vc} >= {1'b0, y_q[i]})
          && ({1'b0, vc} <  {1'b0, y_q[i]} + XW'(BH)))
        pix_d = 1'b1;
    end
  end

  // slot storage, sweep bookkeeping and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      idx_q      <= '0;
      tx_q       <= '0;
      ty_q       <= '0;
      tw_q       <= '0;
      th_q       <= '0;
      cd_q       <= '0;
      cnt_q      <= '0;
      pix_bullet <= 1'b0;
      hit_pulse  <= 1'b0;
      hit_num    <= '0;
      hit_total  <= '0;
      active_cnt <= '0;
      overrun    <= 1'b0;
    end else begin
      hit_pulse  <= 1'b0;
      pix_bullet <= pix_d;
      active_cnt <= pop_d;
      if (tick && state_q != IDLE) overrun <= 1'b1;
      case (state_q)
        IDLE: begin
          if (tick) begin
            tx_q  <= tgt_x;
            ty_q  <= tgt_y;
            tw_q  <= tgt_w;
            th_q  <= tgt_h;
            idx_q <= '0;
            cnt_q <= '0;
          end
        end
        SWEEP: begin
          idx_q <= idx_q + 1'b1;
          if (cur_v) begin
            if (gameover || exits || hit) begin
              valid_q[idx_q] <= 1'b0;
              x_q[idx_q]     <= '0;
              y_q[idx_q]     <= '0;
            end else begin
              y_q[idx_q] <= new_y;
            end
            if (hit) cnt_q <= cnt_q + 5'd1;
          end
        end
        SPAWN: begin
          if (cd_q != '0) cd_q <= cd_q - 8'd1;
          if (do_spawn) begin
            valid_q[free_idx] <= 1'b1;
            x_q[free_idx]     <= spawn_x;
            y_q[free_idx]     <= spawn_y;
            cd_q              <= 8'(COOLDOWN - 1);
          end
          hit_num   <= (cnt_q > 5'd15) ? 4'd15 : cnt_q[3:0];
          hit_pulse <= (cnt_q != '0);
          hit_total <= sum[16] ? 16'hFFFF : sum[15:0];
        end
        default: ;
      endcase
    end
  end
endmodule
